// File: rtl/param_scan_decoder_pkg.sv
// param_scan_decoder_pkg: shared mode encodings and one-hot helper for the scan decoder
package param_scan_decoder_pkg;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Bit b of onehot(i): lets any output width be built bit by bit without a fixed-width return
    function automatic logic onehot(input int unsigned i, input int unsigned b);
        return i == b;
    endfunction

endpackage

// File: rtl/param_scan_decoder_scan_prescaler.sv
// scan_prescaler: free-running step counter that raises tick once cnt reaches period
module scan_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    // >= so that lowering period mid-count still ticks on the next clock
    assign tick = r_cnt >= period;

    // Count while enabled; restart on a tick or an explicit clear, hold when disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (en)
            r_cnt <= (clr || tick) ? '0 : r_cnt + DIV_W'(1);
    end

endmodule

// File: rtl/param_scan_decoder.sv
// param_scan_decoder: registered N-to-2^N one-hot decoder with prescaled auto-scan; SCAN_SKIP_MASK_EN enables mask-based index skipping
module param_scan_decoder
    import param_scan_decoder_pkg::*;
#(
    parameter int N     = 3,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     d,
    input  logic             load,
    input  logic [DIV_W-1:0] period,
    input  logic [2**N-1:0]  mask,
    output logic [2**N-1:0]  q,
    output logic [N-1:0]     idx,
    output logic             wrap
);

    localparam int W = 2**N;

    logic         w_tick;
    logic [N-1:0] w_adv;
    logic         w_adv_ok;
    logic         w_adv_wrap;
    logic [N-1:0] w_idx_nxt;
    logic         w_q_on;
    logic         w_wrap_nxt;
    logic [W-1:0] w_q_nxt;

    logic [N-1:0] r_idx;
    logic [W-1:0] r_q;
    logic         r_wrap;

    assign q    = r_q;
    assign idx  = r_idx;
    assign wrap = r_wrap;

    scan_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (mode == MODE_DECODE || load),
        .period  (period),
        .tick    (w_tick)
    );

`ifdef SCAN_SKIP_MASK_EN
    // Nearest enabled index above r_idx, searching cyclically; descending loop lets the closest hit win
    always_comb begin
        w_adv      = r_idx;
        w_adv_ok   = 1'b0;
        w_adv_wrap = 1'b0;
        for (int k = W; k >= 1; k--) begin
            if (mask[(int'(r_idx) + k) % W]) begin
                w_adv      = N'((int'(r_idx) + k) % W);
                w_adv_ok   = 1'b1;
                w_adv_wrap = int'(r_idx) + k >= W;
            end
        end
    end
`else
    logic w_unused_mask;
    assign w_unused_mask = ^mask;
    assign w_adv         = r_idx + N'(1);
    assign w_adv_ok      = 1'b1;
    assign w_adv_wrap    = &r_idx;
`endif

    // Next index/output selection: enable, then direct index (decode or load), then tick, else hold
    always_comb begin
        w_idx_nxt  = r_idx;
        w_q_on     = 1'b0;
        w_wrap_nxt = 1'b0;
        if (en) begin
            if (mode == MODE_DECODE || load) begin
                w_idx_nxt = d;
                w_q_on    = 1'b1;
            end else if (w_tick) begin
                w_idx_nxt  = w_adv;
                w_q_on     = w_adv_ok;
                w_wrap_nxt = w_adv_ok && w_adv_wrap;
            end else begin
                w_q_on = 1'b1;
            end
        end
    end

    for (genvar b = 0; b < W; b++) begin : g_oh
        assign w_q_nxt[b] = w_q_on && onehot(32'(w_idx_nxt), b);
    end

    // Output and index registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q    <= '0;
            r_idx  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_idx  <= w_idx_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

endmodule

// File: tb/tb_param_scan_decoder.sv
// tb_param_scan_decoder: directed and randomized checks of param_scan_decoder against a behavioural model
module tb_param_scan_decoder;

    localparam int N     = 3;
    localparam int DIV_W = 4;
    localparam int W     = 8;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             en      = 1'b0;
    logic             mode    = 1'b0;
    logic             load    = 1'b0;
    logic [N-1:0]     d       = '0;
    logic [DIV_W-1:0] period  = '0;
    logic [W-1:0]     mask    = '0;
    logic [W-1:0]     q;
    logic [N-1:0]     idx;
    logic             wrap;

    int checks = 0;
    int errors = 0;
    int m_idx  = 0;
    int m_cnt  = 0;
    int m_q    = 0;
    int m_wrap = 0;

    always #5 clk = ~clk;

    param_scan_decoder #(.N(N), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .mode    (mode),
        .d       (d),
        .load    (load),
        .period  (period),
        .mask    (mask),
        .q       (q),
        .idx     (idx),
        .wrap    (wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_advance();
        bit found = 0;
`ifdef SCAN_SKIP_MASK_EN
        for (int k = 1; k <= W; k++) begin
            if (!found && mask[(m_idx + k) % W]) begin
                found  = 1;
                m_wrap = (m_idx + k >= W) ? 1 : 0;
                m_idx  = (m_idx + k) % W;
            end
        end
`else
        found  = 1;
        m_wrap = (m_idx == W - 1) ? 1 : 0;
        m_idx  = (m_idx + 1) % W;
`endif
        if (found) m_q = 1 << m_idx;
        else begin
            m_q    = 0;
            m_wrap = 0;
        end
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            m_idx = 0; m_cnt = 0; m_q = 0; m_wrap = 0;
        end else if (!en) begin
            m_q = 0; m_wrap = 0;
        end else if (!mode || load) begin
            m_idx = d; m_q = 1 << d; m_cnt = 0; m_wrap = 0;
        end else if (m_cnt >= period) begin
            m_cnt = 0;
            model_advance();
        end else begin
            m_cnt++;
            m_q = 1 << m_idx;
            m_wrap = 0;
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_q"}, 32'(q), 32'(m_q));
        check({tag, "_idx"}, 32'(idx), 32'(m_idx));
        check({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
    endtask

    initial begin
        int exp_q[7] = '{'h40, 'h40, 'h80, 'h80, 'h80, 'h01, 'h01};
        int exp_w[7] = '{0, 0, 0, 0, 0, 1, 0};
        #12;
        check("rst_q", 32'(q), 0);
        check("rst_idx", 32'(idx), 0);
        check("rst_wrap", 32'(wrap), 0);
        @(negedge clk);
        reset_n = 1'b1;

        en = 1'b1; mode = 1'b0; d = 3'd5;
        cyc("dec5");
        check("dec5_const_q", 32'(q), 'h20);
        check("dec5_const_idx", 32'(idx), 5);
        for (int i = 0; i < W; i++) begin
            d = N'(i);
            cyc("sweep");
            check("sweep_const_q", 32'(q), 32'(1 << i));
        end

        d = 3'd6;
        cyc("pre_scan");
        mode = 1'b1; period = 4'd2;
        for (int e = 0; e < 7; e++) begin
            cyc("scan_p2");
            check("scan_p2_const_q", 32'(q), 32'(exp_q[e]));
            check("scan_p2_const_wrap", 32'(wrap), 32'(exp_w[e]));
        end

        period = 4'd0; load = 1'b1; d = 3'd3;
        cyc("load_tick");
        check("load_tick_const_q", 32'(q), 'h08);
        check("load_tick_const_wrap", 32'(wrap), 0);
        load = 1'b0;
        cyc("after_load");
        check("after_load_const_q", 32'(q), 'h10);

        period = 4'd2; load = 1'b1; d = 3'd4;
        cyc("load4");
        load = 1'b0;
        cyc("cnt1");
        en = 1'b0;
        cyc("en_off");
        check("en_off_const_q", 32'(q), 0);
        check("en_off_const_idx", 32'(idx), 4);
        en = 1'b1;
        cyc("en_on");
        check("en_on_const_q", 32'(q), 'h10);
        cyc("en_tick");
        check("en_tick_const_q", 32'(q), 'h20);

        period = 4'd1;
        cyc("pre_arst");
        cyc("pre_arst");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_q", 32'(q), 0);
        check("arst_idx", 32'(idx), 0);
        check("arst_wrap", 32'(wrap), 0);
        cyc("arst_hold");
        @(negedge clk);
        reset_n = 1'b1;

`ifdef SCAN_SKIP_MASK_EN
        mode = 1'b0; d = 3'd0;
        cyc("mask_init");
        mode = 1'b1; period = 4'd0; mask = 8'b1000_0101;
        cyc("mask_a");
        check("mask_a_const_idx", 32'(idx), 2);
        cyc("mask_b");
        check("mask_b_const_idx", 32'(idx), 7);
        cyc("mask_c");
        check("mask_c_const_idx", 32'(idx), 0);
        check("mask_c_const_wrap", 32'(wrap), 1);
        cyc("mask_d");
        check("mask_d_const_idx", 32'(idx), 2);
        mask = '0;
        cyc("mask_zero");
        check("mask_zero_const_q", 32'(q), 0);
        check("mask_zero_const_idx", 32'(idx), 2);
`endif

        for (int i = 0; i < 400; i++) begin
            en     = $urandom_range(0, 9) != 0;
            mode   = $urandom_range(0, 3) != 0;
            load   = $urandom_range(0, 7) == 0;
            d      = N'($urandom_range(0, W - 1));
            period = DIV_W'($urandom_range(0, 3));
            mask   = W'($urandom_range(0, 255));
            cyc("rnd");
            if (en && m_q != 0) check("rnd_onehot", 32'($countones(q)), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
